traffic_lamp_monitor: RTL and testbench
=======================================

// Module: traffic_lamp_monitor
// PURPOSE
//   Passive checker on the 6-bit lamp bus driven by the intersection controller.
//   Decodes lamp patterns to phases, measures each phase length in 1 s ticks,
//   checks phase order and duration, and raises a sticky fault code.
//   Sits beside the controller on the same clk; drives status LEDs and the debug bus.
// PARAMETERS
//   G1_SEC   30  expected road-1 green length (s), phase X1D2
//   Y1_SEC   4   expected road-1 yellow length (s), phase V1D2
//   G2_SEC   20  expected road-2 green length (s), phase D1X2
//   Y2_SEC   4   expected road-2 yellow length (s), phase D1V2
//   TOL      1   allowed +/- deviation (s) per phase
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   tick_1s     in   1   one-clk pulse per second, clk domain
//   lamp        in   6   {R1,Y1,G1,R2,Y2,G2}; legal: 001_100, 010_100, 100_001, 100_010
//   clr_fault   in   1   sync pulse: clear fault, return to SYNC
//   phase       out  2   decoded phase: 00 X1D2, 01 V1D2, 10 D1X2, 11 D1V2
//   locked      out  1   1 = phase boundary seen, durations being checked
//   last_len    out  7   length (s) of last completed phase
//   len_stb     out  1   one-clk strobe when last_len updates
//   fault       out  1   sticky fault flag
//   fault_code  out  3   001 illegal pattern, 010 bad order, 011 short, 100 long/stuck
// BEHAVIOUR
//   Reset: phase=00, locked=0, last_len=0, len_stb=0, fault=0, fault_code=000, state=SYNC.
//   lamp registered once (lamp_q); decode and checks use lamp_q; all outputs registered.
//   Boundary: lamp_q != previous lamp_q, both legal. Latency lamp -> phase/len_stb = 2 clk.
//   len counter (7 b, saturates at 127): +1 per tick_1s; on boundary loads 1 if tick_1s
//     same cycle, else 0 (tick on boundary credited to new phase).
//   FSM SYNC -> TRACK -> FAULT:
//     SYNC : first legal boundary -> TRACK, locked=1; partial first phase length not
//            checked, no len_stb.
//     TRACK: each boundary: last_len<=len, len_stb=1; checks, first match wins:
//            next phase != old+1 (mod 4) -> 010; len < exp-TOL -> 011;
//            len > exp+TOL -> 100.
//            Without a boundary, len reaching exp+TOL+1 -> 100 immediately (stuck).
//     Any state: illegal lamp_q (incl. all-off, two greens) -> 001, beats other
//            codes in same cycle.
//     FAULT: fault=1, code frozen (first fault only), locked=0; phase still tracks.
//   clr_fault: fault=0, code=000, -> SYNC; a fault raised in the same cycle wins
//     and is latched.
//   phase holds last legal value while lamp_q illegal.
//   rst mid-operation: all state to reset values immediately; next phase is partial.
// CONFIGURATION
//   TLM_CYCLE_COUNT_EN defined: extra port cycle_cnt out 16, count of fault-free full
//     cycles (D1V2 -> X1D2 boundary in TRACK); wraps 0xFFFF->0; cleared by rst and
//     clr_fault, frozen in FAULT.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Shared package tl_pkg: phase encodings X1D2/V1D2/D1X2/D1V2, lamp pattern
//     constants, fault code constants, FSM state encoding.
//   One sub-module: tl_lamp_decode (combinational lamp -> {legal, phase});
//     checker, counter and FSM stay in this module.
// TESTING
//   Nominal: lamp cycles 30/4/20/4 ticks x3 -> locked after 1st boundary,
//     len_stb values 4,20,4,30,..., fault=0.
//   Illegal: drive 001_001 for 1 clk in TRACK -> fault=1, code=001 2 clk later.
//   Skipped yellow: 001_100 -> 100_001 -> code=010, last_len shown.
//   Short green: road-1 green 28 s (TOL=1) -> code=011 at boundary;
//     29 s -> no fault.
//   Stuck: road-1 green held -> code=100 on 32nd tick, before any boundary.
//   clr_fault in FAULT -> fault=0, locked=0 until next boundary; with
//     TLM_CYCLE_COUNT_EN, 3 clean cycles -> cycle_cnt=3; rst mid-phase clears all.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared phase, lamp pattern, fault code and FSM encodings for the lamp monitor
package tl_pkg;
  typedef enum logic [1:0] {X1D2 = 2'b00, V1D2 = 2'b01, D1X2 = 2'b10, D1V2 = 2'b11} phase_e;
  typedef enum logic [2:0] {
    F_NONE = 3'b000, F_ILLEGAL = 3'b001, F_ORDER = 3'b010, F_SHORT = 3'b011, F_LONG = 3'b100
  } fault_e;
  typedef enum logic [1:0] {SYNC = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_e;
  localparam logic [5:0] LAMP_X1D2 = 6'b001_100;
  localparam logic [5:0] LAMP_V1D2 = 6'b010_100;
  localparam logic [5:0] LAMP_D1X2 = 6'b100_001;
  localparam logic [5:0] LAMP_D1V2 = 6'b100_010;
endpackage

// File: rtl/tl_lamp_decode.sv
// tl_lamp_decode: combinational lamp pattern {R1,Y1,G1,R2,Y2,G2} to {legal, phase}
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [5:0] lamp,
  output logic       legal,
  output phase_e     phase
);
  always_comb begin
    legal = lamp == LAMP_X1D2 || lamp == LAMP_V1D2 || lamp == LAMP_D1X2 || lamp == LAMP_D1V2;
    phase = lamp == LAMP_V1D2 ? V1D2 : lamp == LAMP_D1X2 ? D1X2 : lamp == LAMP_D1V2 ? D1V2 : X1D2;
  end
endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: passive phase order/duration checker on the lamp bus with sticky fault code.
// Optional TLM_CYCLE_COUNT_EN adds cycle_cnt, a count of fault-free full light cycles.
module traffic_lamp_monitor
  import tl_pkg::*;
#(
  parameter int G1_SEC = 30,
  parameter int Y1_SEC = 4,
  parameter int G2_SEC = 20,
  parameter int Y2_SEC = 4,
  parameter int TOL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1s,
  input  logic [5:0]  lamp,
  input  logic        clr_fault,
  output logic [1:0]  phase,
  output logic        locked,
  output logic [6:0]  last_len,
  output logic        len_stb,
  output logic        fault,
  output logic [2:0]  fault_code
`ifdef TLM_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycle_cnt
`endif
);
  logic [5:0] lamp_q, prev_q;
  logic [1:0] vld;
  logic [6:0] len;
  logic cur_legal, prev_legal, bnd, stuck, raise;
  phase_e cur_ph, prev_ph;
  fault_e code_d;
  state_e state, state_d;
  function automatic logic [7:0] exp_of(phase_e p);
    return p == X1D2 ? 8'(G1_SEC) : p == V1D2 ? 8'(Y1_SEC) : p == D1X2 ? 8'(G2_SEC) : 8'(Y2_SEC);
  endfunction
  tl_lamp_decode u_cur (.lamp(lamp_q), .legal(cur_legal), .phase(cur_ph));
  tl_lamp_decode u_prev (.lamp(prev_q), .legal(prev_legal), .phase(prev_ph));
  // vld keeps the post-reset empty samples from looking illegal or forming a boundary
  always_comb begin
    bnd = vld[1] && cur_legal && prev_legal && lamp_q != prev_q;
    stuck = state == TRACK && !bnd && tick_1s && {1'b0, len} >= exp_of(cur_ph) + 8'(TOL);
    code_d = (vld[0] && !cur_legal) ? F_ILLEGAL :
             (state == TRACK && bnd) ? (cur_ph != phase_e'(prev_ph + 2'd1) ? F_ORDER :
                                        {1'b0, len} + 8'(TOL) < exp_of(prev_ph) ? F_SHORT :
                                        {1'b0, len} > exp_of(prev_ph) + 8'(TOL) ? F_LONG : F_NONE) :
             stuck ? F_LONG : F_NONE;
    raise = code_d != F_NONE && (state != FAULT || clr_fault);
    state_d = raise ? FAULT : clr_fault ? SYNC : (state == SYNC && bnd) ? TRACK : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SYNC;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lamp_q <= '0;
      prev_q <= '0;
      vld <= '0;
      len <= '0;
      phase <= '0;
      last_len <= '0;
      len_stb <= 1'b0;
      fault_code <= '0;
    end else begin
      lamp_q <= lamp;
      prev_q <= lamp_q;
      vld <= {vld[0], 1'b1};
      len <= bnd ? {6'd0, tick_1s} : (tick_1s && len != 7'd127) ? len + 7'd1 : len;
      if (vld[0] && cur_legal) phase <= cur_ph;
      len_stb <= state == TRACK && bnd;
      if (state == TRACK && bnd) last_len <= len;
      fault_code <= raise ? code_d : clr_fault ? F_NONE : fault_code;
    end
  assign fault = state == FAULT;
  assign locked = state == TRACK;
`ifdef TLM_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) cycle_cnt <= '0;
    else if (clr_fault) cycle_cnt <= '0;
    else if (state == TRACK && bnd && prev_ph == D1V2 && cur_ph == X1D2 && !raise) cycle_cnt <= cycle_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: directed self-checking bench for traffic_lamp_monitor
module tb_traffic_lamp_monitor;
  localparam logic [5:0] LX = 6'b001_100, LV = 6'b010_100, LG2 = 6'b100_001, LY2 = 6'b100_010;
  logic clk = 1'b0, rst = 1'b1, tick_1s = 1'b0, clr_fault = 1'b0;
  logic [5:0] lamp = LX;
  logic [1:0] phase;
  logic locked, len_stb, fault;
  logic [6:0] last_len;
  logic [2:0] fault_code;
`ifdef TLM_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt;
`endif
  int checks = 0, errors = 0;
  traffic_lamp_monitor dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .lamp(lamp), .clr_fault(clr_fault),
    .phase(phase), .locked(locked), .last_len(last_len), .len_stb(len_stb),
    .fault(fault), .fault_code(fault_code)
`ifdef TLM_CYCLE_COUNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic go(input logic [5:0] v);
    @(negedge clk) lamp = v;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick_1s = 1'b1;
      @(negedge clk) tick_1s = 1'b0;
    end
    @(negedge clk);
  endtask
  task automatic clr();
    @(negedge clk) clr_fault = 1'b1;
    @(negedge clk) clr_fault = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got %b want 00", phase); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (last_len !== 7'd0) begin errors++; $display("FAIL reset_last_len got %0d want 0", last_len); end
    checks++; if (len_stb !== 1'b0) begin errors++; $display("FAIL reset_len_stb got %b want 0", len_stb); end
    checks++; if (fault !== 1'b0 || fault_code !== 3'b000) begin errors++; $display("FAIL reset_fault got %b/%b want 0/000", fault, fault_code); end
  endtask
  task automatic test_nominal();
    logic [5:0] seq [4] = '{LV, LG2, LY2, LX};
    int dur [4] = '{4, 20, 4, 30};
    ticks(5);
    for (int k = 0; k < 12; k++) begin
      go(seq[k % 4]);
      if (k == 0) begin
        checks++; if (locked !== 1'b1 || len_stb !== 1'b0) begin errors++; $display("FAIL nom_sync_lock got locked=%b stb=%b want 1/0", locked, len_stb); end
      end else begin
        checks++; if (len_stb !== 1'b1 || last_len !== 7'(dur[(k + 3) % 4])) begin errors++; $display("FAIL nom_len k=%0d got stb=%b len=%0d want 1/%0d", k, len_stb, last_len, dur[(k + 3) % 4]); end
        checks++; if (phase !== 2'(k % 4 == 3 ? 0 : k % 4 + 1)) begin errors++; $display("FAIL nom_phase k=%0d got %b", k, phase); end
      end
      ticks(dur[k % 4]);
    end
    go(LV);
    checks++; if (len_stb !== 1'b1 || last_len !== 7'd30) begin errors++; $display("FAIL nom_green_len got stb=%b len=%0d want 1/30", len_stb, last_len); end
    @(negedge clk);
    checks++; if (len_stb !== 1'b0) begin errors++; $display("FAIL nom_stb_width got %b want 0", len_stb); end
    checks++; if (fault !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL nom_clean got fault=%b locked=%b want 0/1", fault, locked); end
`ifdef TLM_CYCLE_COUNT_EN
    checks++; if (cycle_cnt !== 16'd3) begin errors++; $display("FAIL nom_cycle_cnt got %0d want 3", cycle_cnt); end
`endif
  endtask
  task automatic test_short();
    ticks(4); go(LG2); ticks(20); go(LY2); ticks(4); go(LX); ticks(29); go(LV);
    checks++; if (fault !== 1'b0 || last_len !== 7'd29) begin errors++; $display("FAIL short29 got fault=%b len=%0d want 0/29", fault, last_len); end
    ticks(4); go(LG2); ticks(20); go(LY2); ticks(4); go(LX); ticks(28); go(LV);
    checks++; if (fault !== 1'b1 || fault_code !== 3'b011 || last_len !== 7'd28) begin errors++; $display("FAIL short28 got fault=%b code=%b len=%0d want 1/011/28", fault, fault_code, last_len); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_locked got %b want 0", locked); end
`ifdef TLM_CYCLE_COUNT_EN
    checks++; if (cycle_cnt !== 16'd5) begin errors++; $display("FAIL short_cycle_cnt got %0d want 5", cycle_cnt); end
`endif
  endtask
  task automatic test_clear();
    clr();
    checks++; if (fault !== 1'b0 || fault_code !== 3'b000 || locked !== 1'b0) begin errors++; $display("FAIL clr got fault=%b code=%b locked=%b want 0/000/0", fault, fault_code, locked); end
`ifdef TLM_CYCLE_COUNT_EN
    checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL clr_cycle_cnt got %0d want 0", cycle_cnt); end
`endif
    ticks(4); go(LG2);
    checks++; if (locked !== 1'b1 || len_stb !== 1'b0) begin errors++; $display("FAIL clr_relock got locked=%b stb=%b want 1/0", locked, len_stb); end
  endtask
  task automatic test_illegal();
    @(negedge clk) lamp = 6'b001_001;
    @(negedge clk) lamp = LG2;
    @(negedge clk);
    checks++; if (fault !== 1'b1 || fault_code !== 3'b001) begin errors++; $display("FAIL illegal got fault=%b code=%b want 1/001", fault, fault_code); end
    checks++; if (phase !== 2'b10) begin errors++; $display("FAIL illegal_phase_hold got %b want 10", phase); end
  endtask
  task automatic test_skip();
    clr(); go(LY2); ticks(4); go(LX);
    checks++; if (len_stb !== 1'b1 || last_len !== 7'd4 || fault !== 1'b0) begin errors++; $display("FAIL skip_pre got stb=%b len=%0d fault=%b want 1/4/0", len_stb, last_len, fault); end
    ticks(10); go(LG2);
    checks++; if (fault !== 1'b1 || fault_code !== 3'b010 || last_len !== 7'd10 || len_stb !== 1'b1) begin errors++; $display("FAIL skip got fault=%b code=%b len=%0d stb=%b want 1/010/10/1", fault, fault_code, last_len, len_stb); end
  endtask
  task automatic test_stuck();
    clr(); go(LY2); ticks(4); go(LX); ticks(31);
    checks++; if (fault !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL stuck_31 got fault=%b locked=%b want 0/1", fault, locked); end
    ticks(1);
    checks++; if (fault !== 1'b1 || fault_code !== 3'b100 || last_len !== 7'd4) begin errors++; $display("FAIL stuck_32 got fault=%b code=%b len=%0d want 1/100/4", fault, fault_code, last_len); end
  endtask
  task automatic test_reset_mid();
    clr(); go(LV); ticks(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || fault !== 1'b0 || fault_code !== 3'b000 || last_len !== 7'd0 || phase !== 2'b00) begin errors++; $display("FAIL rst_mid got locked=%b fault=%b code=%b len=%0d phase=%b want all 0", locked, fault, fault_code, last_len, phase); end
    @(negedge clk) rst = 1'b0;
    ticks(3); go(LG2);
    checks++; if (locked !== 1'b1 || len_stb !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_partial got locked=%b stb=%b fault=%b want 1/0/0", locked, len_stb, fault); end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_clear();
    test_illegal();
    test_skip();
    test_stuck();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
